// File: rtl/display_mux.sv
// display_mux: alternates two synchronized switch digits onto a shared 4-bit
// seven-segment bus, driving one anode per digit with blanking gaps between them.
module display_mux #(
    parameter int unsigned REFRESH_CYCLES = 24000,
    parameter int unsigned BLANK_CYCLES   = 240
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] s1,
    input  logic [3:0] s2,
    output logic [3:0] s_out,
    output logic       anode1_en,
    output logic       anode2_en
);

    localparam int unsigned MAX_CYCLES = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
    localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam int unsigned DIGIT_W    = 4;

    localparam logic [CNT_W-1:0] REFRESH_TC = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_TC   = CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        BLANK1 = 2'd0,
        DIG1   = 2'd1,
        BLANK2 = 2'd2,
        DIG2   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DIGIT_W-1:0] s1_meta_q, s1_sync_q;
    logic [DIGIT_W-1:0] s2_meta_q, s2_sync_q;
    logic [DIGIT_W-1:0] s_out_q, s_out_d;
    logic               anode1_q, anode1_d;
    logic               anode2_q, anode2_d;
    logic [CNT_W-1:0]   term_cnt_c;

    // Two-flop synchronizers for the asynchronous switch digits.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_meta_q <= '0;
            s1_sync_q <= '0;
            s2_meta_q <= '0;
            s2_sync_q <= '0;
        end else begin
            s1_meta_q <= s1;
            s1_sync_q <= s1_meta_q;
            s2_meta_q <= s2;
            s2_sync_q <= s2_meta_q;
        end
    end

    // State, dwell counter and registered display outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= BLANK1;
            cnt_q    <= '0;
            s_out_q  <= '0;
            anode1_q <= 1'b0;
            anode2_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            s_out_q  <= s_out_d;
            anode1_q <= anode1_d;
            anode2_q <= anode2_d;
        end
    end

    // Next state: advance round the fixed ring at terminal count; digit and
    // anode change together on the entry edge so no stale digit is ever lit.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        s_out_d    = s_out_q;
        anode1_d   = anode1_q;
        anode2_d   = anode2_q;
        term_cnt_c = BLANK_TC;

        if (state_q == DIG1 || state_q == DIG2) begin
            term_cnt_c = REFRESH_TC;
        end

        if (cnt_q == term_cnt_c) begin
            cnt_d = '0;
            unique case (state_q)
                BLANK1: begin
                    state_d  = DIG1;
                    s_out_d  = s1_sync_q;
                    anode1_d = 1'b1;
                end
                DIG1: begin
                    state_d  = BLANK2;
                    anode1_d = 1'b0;
                end
                BLANK2: begin
                    state_d  = DIG2;
                    s_out_d  = s2_sync_q;
                    anode2_d = 1'b1;
                end
                DIG2: begin
                    state_d  = BLANK1;
                    anode2_d = 1'b0;
                end
                default: begin
                    state_d = BLANK1;
                end
            endcase
        end
    end

    assign s_out     = s_out_q;
    assign anode1_en = anode1_q;
    assign anode2_en = anode2_q;

endmodule

// File: tb/tb_display_mux.sv
// Directed bench for display_mux: small-parameter instance for sequencing and
// capture checks, default-parameter instance for real-rate timing.
module tb_display_mux;

    logic       clk;
    logic       reset;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [3:0] s_out;
    logic       anode1_en;
    logic       anode2_en;

    logic       reset_d;
    logic [3:0] ds1;
    logic [3:0] ds2;
    logic [3:0] d_s_out;
    logic       d_an1;
    logic       d_an2;

    int total;
    int bad;
    int e;

    display_mux #(.REFRESH_CYCLES(8), .BLANK_CYCLES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .s1        (s1),
        .s2        (s2),
        .s_out     (s_out),
        .anode1_en (anode1_en),
        .anode2_en (anode2_en)
    );

    display_mux dut_def (
        .clk       (clk),
        .reset     (reset_d),
        .s1        (ds1),
        .s2        (ds2),
        .s_out     (d_s_out),
        .anode1_en (d_an1),
        .anode2_en (d_an2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected anode timeline for R=8, B=2; ed counts edges after reset release.
    function automatic logic exp_an1(input int ed);
        return (ed >= 2) && (((ed - 2) % 20) < 8);
    endfunction

    function automatic logic exp_an2(input int ed);
        return (ed >= 2) && (((ed - 2) % 20) >= 10) && (((ed - 2) % 20) < 18);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        e = e + 1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        e = 0;
    endtask

    task automatic test_reset();
        logic [3:0] x;
        s1    = 4'h3;
        s2    = 4'hA;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (anode1_en !== 1'b0) begin bad++; $display("FAIL rst_hold_an1 got=%b exp=0", anode1_en); end
            total++;
            if (anode2_en !== 1'b0) begin bad++; $display("FAIL rst_hold_an2 got=%b exp=0", anode2_en); end
            total++;
            if (s_out !== 4'h0) begin bad++; $display("FAIL rst_hold_sout got=%h exp=0", s_out); end
        end
        reset = 1'b0;
        e = 0;
        for (int i = 0; i < 22; i++) begin
            tick();
            total++;
            if (anode1_en !== exp_an1(e)) begin bad++; $display("FAIL start_an1 edge=%0d got=%b exp=%b", e, anode1_en, exp_an1(e)); end
            total++;
            if (anode2_en !== exp_an2(e)) begin bad++; $display("FAIL start_an2 edge=%0d got=%b exp=%b", e, anode2_en, exp_an2(e)); end
            if (e == 1 || (e >= 12 && e <= 22)) begin
                x = (e == 1) ? 4'h0 : ((e == 22) ? 4'h3 : 4'hA);
                total++;
                if (s_out !== x) begin bad++; $display("FAIL start_sout edge=%0d got=%h exp=%h", e, s_out, x); end
            end
        end
    endtask

    task automatic test_mutex();
        int         gap;
        logic       prev_on;
        logic [3:0] prev_s;
        gap     = 0;
        prev_on = anode1_en | anode2_en;
        prev_s  = s_out;
        for (int i = 0; i < 1000; i++) begin
            if (gap == 0) begin
                s1  = 4'($urandom_range(0, 15));
                s2  = 4'($urandom_range(0, 15));
                gap = $urandom_range(1, 7);
            end else begin
                gap = gap - 1;
            end
            tick();
            total++;
            if ((anode1_en & anode2_en) !== 1'b0) begin bad++; $display("FAIL mutex_both edge=%0d got=%b%b exp=not both", e, anode1_en, anode2_en); end
            total++;
            if (anode1_en !== exp_an1(e)) begin bad++; $display("FAIL mutex_an1 edge=%0d got=%b exp=%b", e, anode1_en, exp_an1(e)); end
            total++;
            if (anode2_en !== exp_an2(e)) begin bad++; $display("FAIL mutex_an2 edge=%0d got=%b exp=%b", e, anode2_en, exp_an2(e)); end
            if (prev_on) begin
                total++;
                if (s_out !== prev_s) begin bad++; $display("FAIL mutex_sout_stable edge=%0d got=%h exp=%h", e, s_out, prev_s); end
            end
            prev_on = anode1_en | anode2_en;
            prev_s  = s_out;
        end
    endtask

    task automatic test_capture();
        logic [3:0] x;
        s1 = 4'h1;
        s2 = 4'h1;
        pulse_reset();
        for (int i = 0; i < 62; i++) begin
            if (e == 4)  s1 = 4'h7;
            if (e == 40) s1 = 4'h9;
            tick();
            if (e >= 12) begin
                if (e < 22)      x = 4'h1;
                else if (e < 32) x = 4'h7;
                else if (e < 42) x = 4'h1;
                else if (e < 52) x = 4'h7;
                else if (e < 62) x = 4'h1;
                else             x = 4'h9;
                total++;
                if (s_out !== x) begin bad++; $display("FAIL capture_sout edge=%0d got=%h exp=%h", e, s_out, x); end
            end
        end
    endtask

    task automatic test_reset_mid();
        s1 = 4'h3;
        s2 = 4'hA;
        pulse_reset();
        repeat (14) tick();
        total++;
        if (anode2_en !== 1'b1 || s_out !== 4'hA) begin bad++; $display("FAIL mid_pre an2=%b sout=%h exp an2=1 sout=a", anode2_en, s_out); end
        reset = 1'b1;
        tick();
        total++;
        if (anode2_en !== 1'b0) begin bad++; $display("FAIL mid_an2 got=%b exp=0", anode2_en); end
        total++;
        if (anode1_en !== 1'b0) begin bad++; $display("FAIL mid_an1 got=%b exp=0", anode1_en); end
        total++;
        if (s_out !== 4'h0) begin bad++; $display("FAIL mid_sout got=%h exp=0", s_out); end
        reset = 1'b0;
        e = 0;
        tick();
        total++;
        if (anode1_en !== 1'b0) begin bad++; $display("FAIL mid_restart_e1 got=%b exp=0", anode1_en); end
        tick();
        total++;
        if (anode1_en !== 1'b1) begin bad++; $display("FAIL mid_restart_e2 got=%b exp=1", anode1_en); end
    endtask

    task automatic test_sweep();
        int         k;
        logic [3:0] x;
        k = 0;
        pulse_reset();
        while (e < 339) begin
            if (e >= 12 && ((e - 12) % 20) == 0 && k < 16) begin
                s1 = 4'(k);
                s2 = 4'(15 - k);
                k  = k + 1;
            end
            tick();
            if (e >= 22 && ((e - 22) % 20) < 8) begin
                x = 4'((e - 22) / 20);
                total++;
                if (anode1_en !== 1'b1 || s_out !== x) begin bad++; $display("FAIL sweep_s1 edge=%0d an1=%b sout=%h exp an1=1 sout=%h", e, anode1_en, s_out, x); end
            end
            if (e >= 32 && ((e - 32) % 20) < 8) begin
                x = 4'(15 - ((e - 32) / 20));
                total++;
                if (anode2_en !== 1'b1 || s_out !== x) begin bad++; $display("FAIL sweep_s2 edge=%0d an2=%b sout=%h exp an2=1 sout=%h", e, anode2_en, s_out, x); end
            end
        end
    endtask

    task automatic test_defaults();
        int c;
        int r1;
        ds1 = 4'h5;
        ds2 = 4'hC;
        total++;
        if (d_an1 !== 1'b0 || d_an2 !== 1'b0) begin bad++; $display("FAIL def_held an1=%b an2=%b exp 0 0", d_an1, d_an2); end
        reset_d = 1'b1;
        tick();
        reset_d = 1'b0;
        c = 0;
        while (d_an1 !== 1'b1 && c < 1000) begin tick(); c++; end
        total++;
        if (c !== 240) begin bad++; $display("FAIL def_first_rise got=%0d exp=240", c); end
        r1 = c;
        while (d_an1 === 1'b1 && c < r1 + 30000) begin
            tick();
            c++;
            if (d_an1 === 1'b1 && d_s_out !== 4'h5) begin
                bad++;
                $display("FAIL def_sout edge=%0d got=%h exp=5", c, d_s_out);
            end
        end
        total++;
        if ((c - r1) !== 24000) begin bad++; $display("FAIL def_width got=%0d exp=24000", c - r1); end
        while (d_an1 !== 1'b1 && c < r1 + 60000) begin tick(); c++; end
        total++;
        if ((c - r1) !== 48480) begin bad++; $display("FAIL def_period got=%0d exp=48480", c - r1); end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        e       = 0;
        reset   = 1'b1;
        reset_d = 1'b1;
        s1      = 4'h0;
        s2      = 4'h0;
        ds1     = 4'h0;
        ds2     = 4'h0;
        test_reset();
        test_mutex();
        test_capture();
        test_reset_mid();
        test_sweep();
        test_defaults();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
